// File: rtl/muldiv_ctrl_pkg.sv
// Shared widths, function codes and FSM encodings for the EX-stage mul/div sequencer.
package muldiv_ctrl_pkg;

    localparam int DATA_W      = 32;
    localparam int DDATA_W     = 64;
    localparam int FUNCT_W     = 6;
    localparam int MUL_LAT_MAX = 8;
    localparam int MUL_CNT_W   = $clog2(MUL_LAT_MAX);

    localparam logic [FUNCT_W-1:0] F_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] F_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_multiplier.sv
// Combinational 32x32->64 multiplier, signed or unsigned; output forced to zero when disabled.
module muldiv_ctrl_multiplier
    import muldiv_ctrl_pkg::*;
(
    input  logic               mul_en,
    input  logic               signed_op,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DDATA_W-1:0] result
);

    logic [DDATA_W-1:0] ext_a;
    logic [DDATA_W-1:0] ext_b;

    // A 64-bit product of sign-extended operands is the exact signed product mod 2^64.
    always_comb begin
        ext_a  = {{DATA_W{signed_op & a[DATA_W-1]}}, a};
        ext_b  = {{DATA_W{signed_op & b[DATA_W-1]}}, b};
        result = mul_en ? (ext_a * ext_b) : '0;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Mul/div sequencer owning HI/LO: MUL_LATENCY-cycle multiply, 32-cycle restoring divide.
// Divider compiled in only when MULDIV_DIV_EN is defined; otherwise DIV/DIVU are ignored.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  operand_1,
    input  logic [DATA_W-1:0]  operand_2,
    input  logic               flush,
    output logic               stall_req,
    output logic               done,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_LATENCY - 1);

    state_t                 state, state_nxt;
    logic [MUL_CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]      mul_a, mul_b;
    logic                   mul_signed;
    logic [DDATA_W-1:0]     product;
    logic                   acc, is_mul, is_div, is_mthi, is_mtlo, mul_cap;

`ifdef MULDIV_DIV_EN
    logic [DATA_W-1:0]      div_q, div_r, div_d, q_step, r_step;
    logic [DATA_W:0]        r_shift, r_diff;
    logic [5:0]             div_cnt;
    logic                   q_neg, r_neg, div_zero, div_last, div_run;
    logic                   a_neg, b_neg;

    always_comb begin
        r_shift  = {div_r, div_q[DATA_W-1]};
        r_diff   = r_shift - {1'b0, div_d};
        q_step   = {div_q[DATA_W-2:0], ~r_diff[DATA_W]};
        r_step   = r_diff[DATA_W] ? r_shift[DATA_W-1:0] : r_diff[DATA_W-1:0];
        div_zero = (div_d == '0);
        div_last = (div_cnt == 6'd31);
        div_run  = (state == S_DIV) && !flush && !div_zero;
        a_neg    = (funct == F_DIV) && operand_1[DATA_W-1];
        b_neg    = (funct == F_DIV) && operand_2[DATA_W-1];
    end
`endif

    always_comb begin
        is_mul  = (funct == F_MULT) || (funct == F_MULTU);
`ifdef MULDIV_DIV_EN
        is_div  = (funct == F_DIV) || (funct == F_DIVU);
`else
        is_div  = 1'b0;
`endif
        is_mthi = (funct == F_MTHI);
        is_mtlo = (funct == F_MTLO);
        acc     = start && !flush && ((state == S_IDLE) || (state == S_DONE));
        mul_cap = (state == S_MUL) && !flush && (cnt == MUL_LAST);
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done      = (state == S_DONE);
                state_nxt = S_IDLE;
                if (acc && is_mul) begin
                    state_nxt = S_MUL;
                    stall_req = 1'b1;
                end else if (acc && is_div) begin
                    state_nxt = S_DIV;
                    stall_req = 1'b1;
                end
            end
            S_MUL: begin
                stall_req = 1'b1;
                if (flush)        state_nxt = S_IDLE;
                else if (mul_cap) state_nxt = S_DONE;
            end
            S_DIV: begin
                stall_req = 1'b1;
`ifdef MULDIV_DIV_EN
                if (flush)                     state_nxt = S_IDLE;
                else if (div_zero || div_last) state_nxt = S_DONE;
`else
                state_nxt = S_IDLE;
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    muldiv_ctrl_multiplier u_mult (
        .mul_en    (state == S_MUL),
        .signed_op (mul_signed),
        .a         (mul_a),
        .b         (mul_b),
        .result    (product)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q      <= '0;
            div_r      <= '0;
            div_d      <= '0;
            div_cnt    <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
`endif
        end else begin
            if (acc && is_mthi) hi <= operand_1;
            if (acc && is_mtlo) lo <= operand_1;
            if (acc && is_mul) begin
                mul_a      <= operand_1;
                mul_b      <= operand_2;
                mul_signed <= (funct == F_MULT);
                cnt        <= '0;
            end else if ((state == S_MUL) && !flush) begin
                cnt <= cnt + 1'b1;
            end
            if (mul_cap) {hi, lo} <= product;
`ifdef MULDIV_DIV_EN
            // Iterate on magnitudes; signs are reapplied only to the final result.
            if (acc && is_div) begin
                div_q   <= neg_if(a_neg, operand_1);
                div_d   <= neg_if(b_neg, operand_2);
                div_r   <= '0;
                div_cnt <= '0;
                q_neg   <= a_neg ^ b_neg;
                r_neg   <= a_neg;
            end else if (div_run) begin
                div_q   <= q_step;
                div_r   <= r_step;
                div_cnt <= div_cnt + 1'b1;
                if (div_last) begin
                    lo <= neg_if(q_neg, q_step);
                    hi <= neg_if(r_neg, r_step);
                end
            end
`endif
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the EX-stage multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the existing combinational `Multiplier` over a pipelined capture window. It runs a 32-iteration restoring divider and owns the architectural HI/LO registers. While an operation is in flight it raises `stall_req` to the pipeline controller.

## Interface
- `MUL_LATENCY`, default 2: cycles spent in MUL before the product is captured; legal range 1..8.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: EX holds a valid mul/div/HI-LO-move instruction this cycle.
- `funct` input `FUNCT_BUS`: instruction function code.
- `operand_1` input `DATA_BUS`: rs value (multiplicand, dividend, or MTHI/MTLO source).
- `operand_2` input `DATA_BUS`: rt value (multiplier or divisor).
- `flush` input 1: pipeline flush; aborts any in-flight operation.
- `stall_req` output 1: hold EX and earlier stages.
- `done` output 1: one-cycle pulse marking HI/LO update complete.
- `hi` output `DATA_BUS`: architectural HI.
- `lo` output `DATA_BUS`: architectural LO.

## Operation
- States: IDLE, MUL, DIV, DONE. DONE accepts a new `start` exactly like IDLE.
- Accept condition: `start && !flush` while in IDLE or DONE.
  - MULT/MULTU: latch operands and funct, set cnt=0, go to MUL.
  - DIV/DIVU: latch operands and funct, go to DIV.
  - MTHI: `hi<=operand_1` at the edge, stay/return IDLE, no stall.
  - MTLO: same as MTHI, targeting `lo`.
  - Any other funct: ignored.
- MUL:
  - `Multiplier` is fed from the latched operands; its output is registered.
  - When cnt==MUL_LATENCY-1: `{hi,lo}<=result` and go to DONE. Otherwise cnt++.
- DIV:
  - Signed operations take magnitudes of both operands first.
  - 32 restoring iterations, one quotient bit per cycle, MSB first.
  - After the last iteration, sign correction:
    - Quotient is negated when the operand signs differ (DIV only).
    - Remainder takes the dividend's sign.
  - `lo<=quotient`, `hi<=remainder`.
  - Divisor==0: no iterations. Go directly to DONE after one DIV cycle; HI/LO unchanged.
- DONE: `done`=1 for one cycle, then IDLE unless a new operation is accepted.
- Signedness: MULT and DIV are signed two's complement; MULTU and DIVU are unsigned.
  - 0x80000000÷0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- `flush` in MUL or DIV: return to IDLE next edge. HI/LO unchanged, no `done`.
- `flush` in IDLE or DONE: blocks acceptance, including MTHI/MTLO.

## Timing
- Reset values: state=IDLE, cnt=0, `hi`=0, `lo`=0, `done`=0, `stall_req`=0.
- `stall_req` is combinational:
  - High in the acceptance cycle of MULT/MULTU/DIV/DIVU.
  - High throughout MUL and DIV.
  - Low in IDLE and DONE otherwise.
- MULT accepted in cycle 0:
  - MUL occupies cycles 1..MUL_LATENCY.
  - HI/LO are valid and `done`=1 in cycle MUL_LATENCY+1.
  - Stall length is MUL_LATENCY+1 cycles.
- DIV accepted in cycle 0:
  - DIV occupies cycles 1..32.
  - HI/LO are valid and `done`=1 in cycle 33.
  - Stall length is 33 cycles.
- Divide by zero: DIV in cycle 1 only, `done` in cycle 2.
- MTHI/MTLO: new value is visible on `hi`/`lo` the cycle after acceptance.
- Back-to-back: a new op accepted in DONE starts with no idle bubble.
- A reset asserted mid-operation wins over everything and restores the reset values at that edge.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: divider datapath, DIV state and the 6-bit iteration counter are compiled in.
  - Undefined: DIV/DIVU are ignored like unknown funct (no stall, no `done`, HI/LO unchanged); divider registers are absent.

## Structure
- Shared headers:
  - `funct.v`: FUNCT_MULT/MULTU/DIV/DIVU/MTHI/MTLO.
  - `bus.v`: DATA_BUS, DOUBLE_DATA_BUS, FUNCT_BUS.
  - New `muldiv.v`: state encodings and the MUL_LATENCY bound.
- One sub-module: instantiate the existing `Multiplier` (mul_en tied to MUL state).
- Divider lives inline behind `MULDIV_DIV_EN`.

## Test plan
- Reset low for 2 cycles → hi=lo=0, stall_req=0, done=0.
  - Then MTHI 0x12345678 → hi=0x12345678 next cycle, stall_req never high.
- MULT 0xFFFFFFFE×0x00000003, MUL_LATENCY=2 → stall cycles 0..2; in cycle 3 done=1, {hi,lo}=0xFFFFFFFF_FFFFFFFA.
  - Same operands with MULTU → {hi,lo}=0x00000002_FFFFFFFA.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → in cycle 33 lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100÷7 → lo=14, hi=2.
- DIVU x÷0 with hi=lo=0xAAAA_AAAA → done in cycle 2, HI/LO unchanged.
- DIV with flush at cycle 10 → IDLE at cycle 11, no done pulse, HI/LO unchanged.
  - A MULT in the flush cycle is not accepted.
- Back-to-back MULT then MULTU accepted in the DONE cycle → no idle cycle between them, two done pulses, final HI/LO from the MULTU.
